// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS-lite datapath; outputs decode from state, with FETCH's irwrite/pcwrite also depending on mem_ready.
// Instruction latency is lw=5, sw=4, R=4, beq=3, j=3 cycles; each mem_ready-low cycle in FETCH/MEMRD/MEMWR adds one.
module mips_multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       aluop1,
  output logic       aluop0,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    RTEXEC = 4'd7,
    RTWB   = 4'd8,
    BEQ    = 4'd9,
    JUMP   = 4'd10
  } state_t;

  state_t state_q, state_d;
  logic   funct_ok;

  assign state = state_q;

  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101,
      6'b101010, 6'b100111, 6'b000000: funct_ok = 1'b1;
      default: funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = FETCH;
    aluop1      = 1'b0;
    aluop0      = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsource    = 2'b00;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    illegal_op  = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        // Illegal encodings fall through to FETCH with no write enable raised.
        if (op == OP_RTYPE && funct_ok)        state_d = RTEXEC;
        else if (op == OP_LW || op == OP_SW)   state_d = MEMADR;
        else if (op == OP_BEQ)                 state_d = BEQ;
        else if (op == OP_J)                   state_d = JUMP;
        else begin
          illegal_op = 1'b1;
          state_d    = FETCH;
        end
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? FETCH : MEMWR;
      end
      RTEXEC: begin
        alusrca = 1'b1;
        aluop1  = 1'b1;
        state_d = RTWB;
      end
      RTWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      BEQ: begin
        alusrca     = 1'b1;
        aluop0      = 1'b1;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
        state_d     = FETCH;
      end
      JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Lockstep bench: each instruction expands to an expected per-cycle state list, checked against a table of control outputs.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       mem_ready;
  logic       aluop1, aluop0, alusrca, pcwrite, pcwritecond, iord, memread, memwrite;
  logic       irwrite, regdst, memtoreg, regwrite, illegal_op;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] state;
  logic [17:0] act;

  int vectors = 0;
  int miscompares = 0;

  mips_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .mem_ready(mem_ready),
    .aluop1(aluop1), .aluop0(aluop0), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsource(pcsource), .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  assign act = {aluop1, aluop0, alusrca, alusrcb, pcsource, pcwrite, pcwritecond, iord,
                memread, memwrite, irwrite, regdst, memtoreg, regwrite, illegal_op};

  // Expected control word for a state number, straight from the per-state output list.
  function automatic logic [17:0] exp_out(int st, logic mr, logic ill);
    logic a1, a0, asa, pw, pwc, io, mrd, mwr, irw, rd, m2r, rw, il;
    logic [1:0] asb, pcs;
    {a1, a0, asa, pw, pwc, io, mrd, mwr, irw, rd, m2r, rw, il} = '0;
    asb = 2'b00; pcs = 2'b00;
    case (st)
      1:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      2:  begin asb = 2'b11; il = ill; end
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mrd = 1; io = 1; end
      5:  begin m2r = 1; rw = 1; end
      6:  begin mwr = 1; io = 1; end
      7:  begin asa = 1; a1 = 1; end
      8:  begin rd = 1; rw = 1; end
      9:  begin asa = 1; a0 = 1; pwc = 1; pcs = 2'b01; end
      10: begin pw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {a1, a0, asa, asb, pcs, pw, pwc, io, mrd, mwr, irw, rd, m2r, rw, il};
  endfunction

  function automatic bit is_legal(logic [5:0] o, logic [5:0] f);
    logic [5:0] fl [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000000};
    if (o == 6'b100011 || o == 6'b101011 || o == 6'b000100 || o == 6'b000010) return 1;
    if (o != 6'b000000) return 0;
    foreach (fl[i]) if (fl[i] == f) return 1;
    return 0;
  endfunction

  // Drives one instruction from its FETCH cycle; entered and left on a falling edge.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fstall, input int mstall);
    int   st_q[$];
    bit   mr_q[$];
    bit   ill;
    int   mw_cycles;
    logic [17:0] e;
    ill = !is_legal(o, f);
    mw_cycles = 0;
    repeat (fstall) begin st_q.push_back(1); mr_q.push_back(0); end
    st_q.push_back(1); mr_q.push_back(1);
    st_q.push_back(2); mr_q.push_back(1'($urandom));
    if (!ill) begin
      case (o)
        6'b100011: begin
          st_q.push_back(3); mr_q.push_back(1'($urandom));
          repeat (mstall) begin st_q.push_back(4); mr_q.push_back(0); end
          st_q.push_back(4); mr_q.push_back(1);
          st_q.push_back(5); mr_q.push_back(1'($urandom));
        end
        6'b101011: begin
          st_q.push_back(3); mr_q.push_back(1'($urandom));
          repeat (mstall) begin st_q.push_back(6); mr_q.push_back(0); end
          st_q.push_back(6); mr_q.push_back(1);
        end
        6'b000100: begin st_q.push_back(9);  mr_q.push_back(1'($urandom)); end
        6'b000010: begin st_q.push_back(10); mr_q.push_back(1'($urandom)); end
        default: begin
          st_q.push_back(7); mr_q.push_back(1'($urandom));
          st_q.push_back(8); mr_q.push_back(1'($urandom));
        end
      endcase
    end
    op = o; funct = f;
    foreach (st_q[i]) begin
      mem_ready = mr_q[i];
      #1;
      e = exp_out(st_q[i], mr_q[i], ill);
      vectors++;
      if (state !== 4'(st_q[i])) begin
        miscompares++;
        $display("FAIL state op=%b funct=%b cyc=%0d: got %0d want %0d", o, f, i, state, st_q[i]);
      end
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL outputs op=%b st=%0d mr=%b: got %b want %b", o, st_q[i], mr_q[i], act, e);
      end
      vectors++;
      if ((memread && memwrite) || (regwrite && (pcwrite || pcwritecond)) || (aluop1 && aluop0)) begin
        miscompares++;
        $display("FAIL exclusivity st=%0d: got %b want no conflicting enables", state, act);
      end
      if (memwrite === 1'b1) mw_cycles++;
      @(posedge clk);
      @(negedge clk);
    end
    if (o == 6'b101011 && !ill) begin
      vectors++;
      if (mw_cycles != mstall + 1) begin
        miscompares++;
        $display("FAIL sw_memwrite_len: got %0d want %0d", mw_cycles, mstall + 1);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if (state !== 4'd0 || act !== 18'd0) begin
      miscompares++;
      $display("FAIL %s: got state=%0d out=%b want state=0 out=0", tag, state, act);
    end
  endtask

  task automatic test_reset;
    rst_n = 0; mem_ready = 1; op = 6'b100011; funct = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_hold");
    rst_n = 1;
    #1;
    check_all_zero("idle_after_release");
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_lw;      run_instr(6'b100011, 6'b000000, 0, 0); endtask
  task automatic test_rtype;   run_instr(6'b000000, 6'b101010, 0, 0); endtask
  task automatic test_sw_stall; run_instr(6'b101011, 6'b010101, 1, 3); endtask
  task automatic test_beq_j;
    run_instr(6'b000100, 6'b111111, 0, 0);
    run_instr(6'b000010, 6'b000000, 0, 0);
  endtask
  task automatic test_illegal;
    run_instr(6'b001000, 6'b100000, 0, 0);
    run_instr(6'b000000, 6'b100110, 0, 0);
  endtask

  task automatic test_reset_mid;
    op = 6'b100011; funct = 0; mem_ready = 1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    mem_ready = 0;
    #1;
    vectors++;
    if (state !== 4'd4) begin
      miscompares++;
      $display("FAIL reach_memrd: got %0d want 4", state);
    end
    rst_n = 0;
    #1;
    check_all_zero("async_reset_mid");
    @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_mid_hold");
    rst_n = 1;
    #1;
    check_all_zero("idle_after_mid_release");
    @(posedge clk);
    @(negedge clk);
    run_instr(6'b100011, 6'b000000, 0, 1);
  endtask

  task automatic test_back_to_back;
    logic [5:0] ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000000};
    logic [5:0] fl  [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000000};
    logic [5:0] o, f;
    for (int n = 0; n < 60; n++) begin
      o = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) o = 6'($urandom);
      f = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fl[$urandom_range(0, 6)];
      run_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_sw_stall();
    test_beq_j();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
